// File: rtl/riscv_core_fetch_queue.sv
// riscv_core_fetch_queue
//
// Purpose:
//   Small circular-buffer queue between instruction fetch and decode. Each
//   entry carries the fetched instruction word, its PC and a fetch-fault flag.
//   The head entry is presented combinationally to the decoder. An empty
//   queue presents a NOP with PC 0 and no fault. A flush discards every entry
//   on the next clock edge.
//
// Ports:
//   i_clk, i_rst         clock and asynchronous active-high reset
//   i_fq_push_valid      fetch offers an entry
//   i_fq_push_instr      fetched instruction word
//   i_fq_push_pc         PC of that instruction
//   i_fq_push_fault      fetch access fault / misalignment for that entry
//   o_fq_push_ready      queue can accept an entry this cycle
//   o_fq_instr           head instruction (to decoder)
//   o_fq_pc              head PC
//   o_fq_if_illegal      head fault flag (to decoder)
//   o_fq_valid           head entry valid
//   i_fq_pop_ready       decode consumes the head
//   i_fq_flush           discard all entries (redirect or trap)
//   o_fq_count           current occupancy, 0..DEPTH

module riscv_core_fetch_queue #(
  parameter int DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_fq_push_valid,
  input  logic [31:0]                i_fq_push_instr,
  input  logic [63:0]                i_fq_push_pc,
  input  logic                       i_fq_push_fault,
  output logic                       o_fq_push_ready,
  output logic [31:0]                o_fq_instr,
  output logic [63:0]                o_fq_pc,
  output logic                       o_fq_if_illegal,
  output logic                       o_fq_valid,
  input  logic                       i_fq_pop_ready,
  input  logic                       i_fq_flush,
  output logic [$clog2(DEPTH):0]     o_fq_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Entry storage is deliberately left out of reset; count gates its use.
  logic [31:0] instr_mem [DEPTH];
  logic [63:0] pc_mem    [DEPTH];
  logic        fault_mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;

  logic push_fire;
  logic pop_fire;

  // Flush blocks both handshakes so nothing moves in the flush cycle.
  assign o_fq_push_ready = (count != FULL_COUNT) && !i_fq_flush;
  assign o_fq_valid      = (count != '0);
  assign push_fire       = i_fq_push_valid && o_fq_push_ready;
  assign pop_fire        = o_fq_valid && i_fq_pop_ready && !i_fq_flush;
  assign o_fq_count      = count;

  always_ff @(posedge i_clk) begin
    if (push_fire) begin
      instr_mem[wr_ptr] <= i_fq_push_instr;
      pc_mem[wr_ptr]    <= i_fq_push_pc;
      fault_mem[wr_ptr] <= i_fq_push_fault;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (i_fq_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_fire) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_fire) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      // Simultaneous push and pop leaves occupancy unchanged.
      if (push_fire && !pop_fire) begin
        count <= count + 1'b1;
      end else if (pop_fire && !push_fire) begin
        count <= count - 1'b1;
      end
    end
  end

  // An empty queue shows a harmless NOP so decode never sees stale data.
  always_comb begin
    o_fq_instr      = NOP_INSTR;
    o_fq_pc         = '0;
    o_fq_if_illegal = 1'b0;
    if (count != '0) begin
      o_fq_instr      = instr_mem[rd_ptr];
      o_fq_pc         = pc_mem[rd_ptr];
      o_fq_if_illegal = fault_mem[rd_ptr];
    end
  end

endmodule

// File: tb/tb_riscv_core_fetch_queue.sv
// tb_riscv_core_fetch_queue
//
// Purpose:
//   Directed, table-driven bench for riscv_core_fetch_queue. Each table row
//   gives the inputs for one cycle, the ready value expected before the edge
//   and the head/count expected after it. Asynchronous reset and pointer
//   wrap are covered by hand-written sequences.

module tb_riscv_core_fetch_queue;

  logic        clk;
  logic        rst;
  logic        push_valid;
  logic [31:0] push_instr;
  logic [63:0] push_pc;
  logic        push_fault;
  logic        push_ready;
  logic [31:0] head_instr;
  logic [63:0] head_pc;
  logic        head_illegal;
  logic        head_valid;
  logic        pop_ready;
  logic        flush;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        push_valid;
    logic [31:0] instr;
    logic [63:0] pc;
    logic        fault;
    logic        pop_ready;
    logic        flush;
    logic        exp_ready;
    logic [2:0]  exp_count;
    logic [31:0] exp_instr;
    logic [63:0] exp_pc;
    logic        exp_illegal;
  } vec_t;

  vec_t vecs[$];

  riscv_core_fetch_queue #(.DEPTH(4)) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_fq_push_valid (push_valid),
    .i_fq_push_instr (push_instr),
    .i_fq_push_pc    (push_pc),
    .i_fq_push_fault (push_fault),
    .o_fq_push_ready (push_ready),
    .o_fq_instr      (head_instr),
    .o_fq_pc         (head_pc),
    .o_fq_if_illegal (head_illegal),
    .o_fq_valid      (head_valid),
    .i_fq_pop_ready  (pop_ready),
    .i_fq_flush      (flush),
    .o_fq_count      (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic pv, input logic [31:0] in, input logic [63:0] pc,
                              input logic ft, input logic pr, input logic fl, input logic er,
                              input logic [2:0] ec, input logic [31:0] ei,
                              input logic [63:0] ep, input logic eil);
    vec_t v;
    v.push_valid = pv; v.instr = in; v.pc = pc; v.fault = ft;
    v.pop_ready = pr; v.flush = fl; v.exp_ready = er; v.exp_count = ec;
    v.exp_instr = ei; v.exp_pc = ep; v.exp_illegal = eil;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Compares every head output plus count/valid against one expectation.
  task automatic checkHead(input string tag, input logic [2:0] ec, input logic [31:0] ei,
                           input logic [63:0] ep, input logic eil);
    checkOutput({tag, " count"},   64'(count),        64'(ec));
    checkOutput({tag, " valid"},   64'(head_valid),   64'(ec != 3'd0));
    checkOutput({tag, " instr"},   64'(head_instr),   64'(ei));
    checkOutput({tag, " pc"},      head_pc,           ep);
    checkOutput({tag, " illegal"}, 64'(head_illegal), 64'(eil));
  endtask

  // Drives one row starting just after an edge, checks ready before the
  // next edge and the resulting head state just after it.
  task automatic applyStimulus(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("vec%0d", idx);
    push_valid = v.push_valid;
    push_instr = v.instr;
    push_pc    = v.pc;
    push_fault = v.fault;
    pop_ready  = v.pop_ready;
    flush      = v.flush;
    #1;
    checkOutput({tag, " ready"}, 64'(push_ready), 64'(v.exp_ready));
    @(posedge clk);
    #1;
    checkHead(tag, v.exp_count, v.exp_instr, v.exp_pc, v.exp_illegal);
  endtask

  task automatic idleInputs();
    push_valid = 1'b0;
    push_instr = '0;
    push_pc    = '0;
    push_fault = 1'b0;
    pop_ready  = 1'b0;
    flush      = 1'b0;
  endtask

  localparam logic [31:0] NOP = 32'h0000_0013;

  initial begin
    idleInputs();
    rst = 1'b1;

    // Fill, then drain in order
    vecs.push_back(mk(1, 32'h00A00093, 64'h1000, 0, 0, 0, 1, 3'd1, 32'h00A00093, 64'h1000, 0));
    vecs.push_back(mk(1, 32'h00B00113, 64'h1004, 0, 0, 0, 1, 3'd2, 32'h00A00093, 64'h1000, 0));
    vecs.push_back(mk(1, 32'h00C00193, 64'h1008, 0, 0, 0, 1, 3'd3, 32'h00A00093, 64'h1000, 0));
    vecs.push_back(mk(1, 32'h00D00213, 64'h100C, 0, 0, 0, 1, 3'd4, 32'h00A00093, 64'h1000, 0));
    vecs.push_back(mk(0, 32'h0,        64'h0,    0, 0, 0, 0, 3'd4, 32'h00A00093, 64'h1000, 0));
    vecs.push_back(mk(0, 32'h0,        64'h0,    0, 1, 0, 0, 3'd3, 32'h00B00113, 64'h1004, 0));
    vecs.push_back(mk(0, 32'h0,        64'h0,    0, 1, 0, 1, 3'd2, 32'h00C00193, 64'h1008, 0));
    vecs.push_back(mk(0, 32'h0,        64'h0,    0, 1, 0, 1, 3'd1, 32'h00D00213, 64'h100C, 0));
    vecs.push_back(mk(0, 32'h0,        64'h0,    0, 1, 0, 1, 3'd0, NOP,          64'h0,    0));
    // Pop while empty is a no-op
    vecs.push_back(mk(0, 32'h0,        64'h0,    0, 1, 0, 1, 3'd0, NOP,          64'h0,    0));
    // Fault travels with its entry; push+pop at count 1
    vecs.push_back(mk(1, 32'h00000073, 64'h2000, 1, 0, 0, 1, 3'd1, 32'h00000073, 64'h2000, 1));
    vecs.push_back(mk(1, 32'h00100113, 64'h2004, 0, 1, 0, 1, 3'd1, 32'h00100113, 64'h2004, 0));
    // Push+pop at count 2, then push+pop while full
    vecs.push_back(mk(1, 32'h00200193, 64'h2008, 0, 0, 0, 1, 3'd2, 32'h00100113, 64'h2004, 0));
    vecs.push_back(mk(1, 32'h00300213, 64'h200C, 0, 1, 0, 1, 3'd2, 32'h00200193, 64'h2008, 0));
    vecs.push_back(mk(1, 32'h00400293, 64'h2010, 0, 0, 0, 1, 3'd3, 32'h00200193, 64'h2008, 0));
    vecs.push_back(mk(1, 32'h00500313, 64'h2014, 0, 0, 0, 1, 3'd4, 32'h00200193, 64'h2008, 0));
    vecs.push_back(mk(1, 32'h00600393, 64'h2018, 0, 1, 0, 0, 3'd3, 32'h00300213, 64'h200C, 0));
    vecs.push_back(mk(0, 32'h0,        64'h0,    0, 1, 0, 1, 3'd2, 32'h00400293, 64'h2010, 0));
    vecs.push_back(mk(0, 32'h0,        64'h0,    0, 1, 0, 1, 3'd1, 32'h00500313, 64'h2014, 0));
    vecs.push_back(mk(0, 32'h0,        64'h0,    0, 1, 0, 1, 3'd0, NOP,          64'h0,    0));
    // Flush at count 3 with push and pop also requested
    vecs.push_back(mk(1, 32'h01000093, 64'h3000, 0, 0, 0, 1, 3'd1, 32'h01000093, 64'h3000, 0));
    vecs.push_back(mk(1, 32'h01100113, 64'h3004, 0, 0, 0, 1, 3'd2, 32'h01000093, 64'h3000, 0));
    vecs.push_back(mk(1, 32'h01200193, 64'h3008, 0, 0, 0, 1, 3'd3, 32'h01000093, 64'h3000, 0));
    vecs.push_back(mk(1, 32'h01300213, 64'h300C, 0, 1, 1, 0, 3'd0, NOP,          64'h0,    0));
    vecs.push_back(mk(1, 32'h00100093, 64'h4000, 0, 0, 0, 1, 3'd1, 32'h00100093, 64'h4000, 0));
    vecs.push_back(mk(0, 32'h0,        64'h0,    0, 1, 0, 1, 3'd0, NOP,          64'h0,    0));

    // Reset state while reset is held
    @(posedge clk);
    @(posedge clk);
    #1;
    checkHead("reset", 3'd0, NOP, 64'h0, 1'b0);
    checkOutput("reset ready", 64'(push_ready), 64'd1);
    rst = 1'b0;

    // The first row pushes on the first edge after reset release
    foreach (vecs[i]) applyStimulus(i, vecs[i]);

    // Asynchronous reset mid-stream at count 2
    applyStimulus(100, mk(1, 32'hAAAA0001, 64'h5000, 1, 0, 0, 1, 3'd1, 32'hAAAA0001, 64'h5000, 1));
    applyStimulus(101, mk(1, 32'hAAAA0002, 64'h5004, 0, 0, 0, 1, 3'd2, 32'hAAAA0001, 64'h5000, 1));
    idleInputs();
    #2;
    rst = 1'b1;
    #1;
    checkHead("async_rst", 3'd0, NOP, 64'h0, 1'b0);
    checkOutput("async_rst ready", 64'(push_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus(102, mk(1, 32'hBBBB0001, 64'h6000, 0, 0, 0, 1, 3'd1, 32'hBBBB0001, 64'h6000, 0));

    // Ten push+pop cycles at count 1 walk both pointers past the wrap
    for (int i = 0; i < 10; i++) begin
      applyStimulus(200 + i, mk(1, 32'hC0000000 + 32'(i), 64'h7000 + 64'(4 * i), 0, 1, 0, 1,
                                3'd1, 32'hC0000000 + 32'(i), 64'h7000 + 64'(4 * i), 0));
    end
    applyStimulus(210, mk(0, 32'h0, 64'h0, 0, 1, 0, 1, 3'd0, NOP, 64'h0, 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
